// File: rtl/branch_predictor_btb_if.sv
// Lookup, update and statistics signals of the branch predictor / BTB.
// The master side (fetch/execute logic or a bench) drives lookups and
// resolved-branch updates; the slave side (the predictor) answers.
interface branch_predictor_btb_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] lookup_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            pred_hit;

    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic [XLEN-1:0] upd_target;
    logic [XLEN-1:0] upd_pred_target;
    logic            upd_taken;
    logic            upd_pred_taken;
    logic            flush;

    logic            mispredict;
    logic [31:0]     br_count;
    logic [31:0]     mispred_count;

    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_target, upd_pred_target,
               upd_taken, upd_pred_taken, flush,
        input  pred_taken, pred_target, pred_hit, mispredict,
               br_count, mispred_count
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_target, upd_pred_target,
               upd_taken, upd_pred_taken, flush,
        output pred_taken, pred_target, pred_hit, mispredict,
               br_count, mispred_count
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Lookup is combinational from the registered table (no bypass of
// a same-cycle update). Only taken branches allocate entries. Flush drops
// all valid bits but keeps counters/targets. Reset is asynchronous, active low.
module branch_predictor_btb #(
    parameter int ENTRIES  = 16,
    parameter int CNT_BITS = 2,
    parameter int XLEN     = 32
) (
    input  logic clk,
    input  logic rst,
    branch_predictor_btb_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    typedef logic [CNT_BITS-1:0] cnt_t;
    localparam cnt_t CNT_WT  = cnt_t'(1 << (CNT_BITS - 1));
    localparam cnt_t CNT_WNT = cnt_t'((1 << (CNT_BITS - 1)) - 1);
    localparam cnt_t CNT_MAX = cnt_t'((1 << CNT_BITS) - 1);

    // Flattened read views of the per-entry registers.
    logic [ENTRIES-1:0] valid_all;
    logic [TAG_W-1:0]   tag_all    [ENTRIES];
    logic [XLEN-1:0]    target_all [ENTRIES];
    cnt_t               cnt_all    [ENTRIES];

    // Lookup side decode.
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_taken;
    logic [XLEN-1:0]  lk_target;

    // Update side decode.
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    cnt_t             up_cnt_next;

    logic [31:0] br_count_reg;
    logic [31:0] mispred_count_reg;

    // Word-alignment bits never take part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

    assign lk_idx = bus.lookup_pc[IDX_W+1:2];
    assign lk_tag = bus.lookup_pc[XLEN-1:IDX_W+2];
    assign up_idx = bus.upd_pc[IDX_W+1:2];
    assign up_tag = bus.upd_pc[XLEN-1:IDX_W+2];

    // Prediction from current table contents; fall-through is pc+4.
    always_comb begin
        lk_hit    = valid_all[lk_idx] && (tag_all[lk_idx] == lk_tag);
        lk_taken  = lk_hit && cnt_all[lk_idx][CNT_BITS-1];
        lk_target = lk_taken ? target_all[lk_idx] : bus.lookup_pc + XLEN'(4);
    end

    // Hit check and saturating counter step for the resolving branch.
    always_comb begin
        up_hit      = valid_all[up_idx] && (tag_all[up_idx] == up_tag);
        up_cnt_next = cnt_all[up_idx];
        if (bus.upd_taken) begin
            if (cnt_all[up_idx] != CNT_MAX)
                up_cnt_next = cnt_all[up_idx] + cnt_t'(1);
        end else begin
            if (cnt_all[up_idx] != '0)
                up_cnt_next = cnt_all[up_idx] - cnt_t'(1);
        end
    end

    assign bus.pred_hit    = lk_hit;
    assign bus.pred_taken  = lk_taken;
    assign bus.pred_target = lk_target;
    assign bus.mispredict  = bus.upd_valid &&
                             ((bus.upd_taken != bus.upd_pred_taken) ||
                              (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             valid_reg;
            logic [TAG_W-1:0] tag_reg;
            logic [XLEN-1:0]  target_reg;
            cnt_t             cnt_reg;
            logic             sel;

            assign sel = bus.upd_valid && (up_idx == IDX_W'(gi));

            // Entry state: flush beats update; hits train, taken misses allocate.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    cnt_reg    <= CNT_WNT;
                end else if (bus.flush) begin
                    valid_reg <= 1'b0;
                end else if (sel) begin
                    if (up_hit) begin
                        cnt_reg <= up_cnt_next;
                        if (bus.upd_taken)
                            target_reg <= bus.upd_target;
                    end else if (bus.upd_taken) begin
                        valid_reg  <= 1'b1;
                        tag_reg    <= up_tag;
                        target_reg <= bus.upd_target;
                        cnt_reg    <= CNT_WT;
                    end
                end
            end

            assign valid_all[gi]  = valid_reg;
            assign tag_all[gi]    = tag_reg;
            assign target_all[gi] = target_reg;
            assign cnt_all[gi]    = cnt_reg;
        end
    endgenerate

    // Saturating statistics; they count updates even when a flush masks them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_count_reg      <= '0;
            mispred_count_reg <= '0;
        end else begin
            if (bus.upd_valid && (br_count_reg != 32'hFFFF_FFFF))
                br_count_reg <= br_count_reg + 32'd1;
            if (bus.mispredict && (mispred_count_reg != 32'hFFFF_FFFF))
                mispred_count_reg <= mispred_count_reg + 32'd1;
        end
    end

    assign bus.br_count      = br_count_reg;
    assign bus.mispred_count = mispred_count_reg;
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed table-driven bench for branch_predictor_btb (ENTRIES=16,
// CNT_BITS=2, XLEN=32), plus sequences for flush, same-cycle lookup/update
// and asynchronous reset.
module tb_branch_predictor_btb;
    logic clk;
    logic rst_n;

    branch_predictor_btb_if #(.XLEN(32)) bus ();

    branch_predictor_btb #(.ENTRIES(16), .CNT_BITS(2), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        emis;
        logic [31:0] lpc;
        logic        ehit;
        logic        etaken;
        logic [31:0] etgt;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_br    = 0;
    int exp_mis   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic uv, input logic [31:0] upc, input logic ut,
                                input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt,
                                input logic emis, input logic [31:0] lpc, input logic ehit,
                                input logic etaken, input logic [31:0] etgt);
        vec_t v;
        v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upt = upt; v.uptgt = uptgt;
        v.emis = emis; v.lpc = lpc; v.ehit = ehit; v.etaken = etaken; v.etgt = etgt;
        return v;
    endfunction

    task automatic drive_upd(input logic uv, input logic [31:0] upc, input logic ut,
                             input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt);
        bus.upd_valid       = uv;
        bus.upd_pc          = upc;
        bus.upd_taken       = ut;
        bus.upd_target      = utgt;
        bus.upd_pred_taken  = upt;
        bus.upd_pred_target = uptgt;
    endtask

    task automatic chk_lookup(input string name, input logic [31:0] pc, input logic hit,
                              input logic taken, input logic [31:0] tgt);
        bus.lookup_pc = pc;
        #1;
        chk({name, "_hit"},    32'(bus.pred_hit),   32'(hit));
        chk({name, "_taken"},  32'(bus.pred_taken), 32'(taken));
        chk({name, "_target"}, bus.pred_target,     tgt);
    endtask

    initial begin
        // 0x100, 0x140, 0x200 all map to index 0 with different tags.
        //            uv  upc        ut  utgt       upt uptgt      mis lpc           hit tk  tgt
        vecs[0]  = mk(1, 32'h100, 1, 32'h080, 0, 32'h000, 1, 32'h100,      1, 1, 32'h080);
        vecs[1]  = mk(1, 32'h100, 1, 32'h080, 1, 32'h080, 0, 32'h100,      1, 1, 32'h080);
        vecs[2]  = mk(1, 32'h100, 1, 32'h080, 1, 32'h080, 0, 32'h100,      1, 1, 32'h080);
        vecs[3]  = mk(1, 32'h100, 1, 32'h080, 1, 32'h080, 0, 32'h100,      1, 1, 32'h080);
        vecs[4]  = mk(1, 32'h100, 0, 32'h000, 1, 32'h080, 1, 32'h100,      1, 1, 32'h080);
        vecs[5]  = mk(1, 32'h100, 0, 32'h000, 1, 32'h080, 1, 32'h100,      1, 0, 32'h104);
        vecs[6]  = mk(1, 32'h100, 0, 32'h000, 0, 32'h000, 0, 32'h100,      1, 0, 32'h104);
        vecs[7]  = mk(1, 32'h100, 1, 32'h080, 0, 32'h000, 1, 32'h100,      1, 0, 32'h104);
        vecs[8]  = mk(1, 32'h100, 1, 32'h300, 1, 32'h080, 1, 32'h100,      1, 1, 32'h300);
        vecs[9]  = mk(1, 32'h140, 0, 32'h000, 0, 32'h000, 0, 32'h140,      0, 0, 32'h144);
        vecs[10] = mk(1, 32'h140, 1, 32'h040, 0, 32'h000, 1, 32'h140,      1, 1, 32'h040);
        vecs[11] = mk(0, 32'h100, 1, 32'h080, 0, 32'h000, 0, 32'h100,      0, 0, 32'h104);
        vecs[12] = mk(1, 32'h104, 1, 32'h1000, 1, 32'h1000, 0, 32'h104,    1, 1, 32'h1000);
        vecs[13] = mk(0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h140,      1, 1, 32'h040);
        vecs[14] = mk(0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'hFFFFFFFC, 0, 0, 32'h000);

        // Reset state, observed while reset is held.
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.lookup_pc = 32'h100;
        drive_upd(0, 0, 0, 0, 0, 0);
        #1;
        chk_lookup("reset", 32'h100, 0, 0, 32'h104);
        chk("reset_br",  bus.br_count,      32'd0);
        chk("reset_mis", bus.mispred_count, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_lookup("cold", 32'h100, 0, 0, 32'h104);
        @(negedge clk);

        // Main table: update, edge, lookup.
        for (int i = 0; i < NV; i++) begin
            drive_upd(vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt, vecs[i].upt, vecs[i].uptgt);
            #1;
            chk($sformatf("v%0d_mispredict", i), 32'(bus.mispredict), 32'(vecs[i].emis));
            exp_br  += int'(vecs[i].uv);
            exp_mis += int'(vecs[i].emis);
            @(posedge clk);
            #1;
            bus.upd_valid = 1'b0;
            chk_lookup($sformatf("v%0d", i), vecs[i].lpc, vecs[i].ehit, vecs[i].etaken, vecs[i].etgt);
            @(negedge clk);
        end
        chk("table_br",  bus.br_count,      32'(exp_br));
        chk("table_mis", bus.mispred_count, 32'(exp_mis));

        // Flush with a same-cycle taken update: table cleared, stats still count.
        bus.flush = 1'b1;
        drive_upd(1, 32'h200, 1, 32'h500, 0, 32'h000);
        #1;
        chk("flush_mispredict", 32'(bus.mispredict), 32'd1);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.upd_valid = 1'b0;
        chk_lookup("flush_104", 32'h104, 0, 0, 32'h108);
        chk_lookup("flush_140", 32'h140, 0, 0, 32'h144);
        chk_lookup("flush_200", 32'h200, 0, 0, 32'h204);
        chk("flush_br",  bus.br_count,      32'(exp_br + 1));
        chk("flush_mis", bus.mispred_count, 32'(exp_mis + 1));
        @(negedge clk);

        // Same-cycle lookup and update: old contents before the edge, new after.
        bus.lookup_pc = 32'h200;
        drive_upd(1, 32'h200, 1, 32'h600, 0, 32'h000);
        #1;
        chk("bypass_pre_hit",    32'(bus.pred_hit), 32'd0);
        chk("bypass_pre_target", bus.pred_target,   32'h204);
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
        chk_lookup("bypass_post", 32'h200, 1, 1, 32'h600);
        chk("bypass_br",  bus.br_count,      32'(exp_br + 2));
        chk("bypass_mis", bus.mispred_count, 32'(exp_mis + 2));
        @(negedge clk);

        // Asynchronous reset between edges, with an update pending.
        drive_upd(1, 32'h300, 1, 32'h700, 0, 32'h000);
        #2;
        rst_n = 1'b0;
        #1;
        chk_lookup("areset", 32'h200, 0, 0, 32'h204);
        chk("areset_br",         bus.br_count,        32'd0);
        chk("areset_mis",        bus.mispred_count,   32'd0);
        chk("areset_mispredict", 32'(bus.mispredict), 32'd1);
        @(posedge clk);
        #1;
        chk_lookup("areset_edge", 32'h300, 0, 0, 32'h304);
        chk("areset_edge_br", bus.br_count, 32'd0);
        @(negedge clk);
        bus.upd_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_lookup("post_reset", 32'h300, 0, 0, 32'h304);
        @(negedge clk);

        // Normal operation resumes after reset.
        drive_upd(1, 32'h300, 1, 32'h700, 0, 32'h000);
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
        chk_lookup("resume", 32'h300, 1, 1, 32'h700);
        chk("resume_br",  bus.br_count,      32'd1);
        chk("resume_mis", bus.mispred_count, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/branch_predictor_btb.md
BRANCH_PREDICTOR_BTB -- requirements
Module: branch_predictor_btb

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, table depth (power of 2, 2..1024); IDX_W = log2(ENTRIES).
REQ-002 SHALL have parameter CNT_BITS, default 2, saturating-counter width (1..3).
REQ-003 SHALL have parameter XLEN, default 32, address width; TAG_W = XLEN-IDX_W-2.
REQ-004 Port clk  input  1  single clock, all state on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset.
REQ-006 Port lookup_pc  input  XLEN  IF-stage PC.
REQ-007 Port pred_taken  output  1  predicted direction for lookup_pc.
REQ-008 Port pred_target  output  XLEN  predicted next PC.
REQ-009 Port pred_hit  output  1  valid tag match for lookup_pc.
REQ-010 Port upd_valid  input  1  EX-stage resolved branch/jump this cycle.
REQ-011 Port upd_pc, upd_target, upd_pred_target  input  XLEN each  resolved PC, actual target, target predicted earlier.
REQ-012 Port upd_taken, upd_pred_taken  input  1 each  actual and predicted direction.
REQ-013 Port flush  input  1  synchronous invalidate of all entries.
REQ-014 Port mispredict  output  1  combinational, high when the current update is mispredicted.
REQ-015 Port br_count, mispred_count  output  32 each  statistics counters.

Function
REQ-016 Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; entry = {valid, tag, target, counter}.
REQ-017 Lookup SHALL be combinational from registered table: pred_hit = valid && tag match; pred_taken = pred_hit && counter MSB; pred_target = entry target when pred_taken, else lookup_pc+4 (mod 2^XLEN).
REQ-018 Lookup and update to the same index in one cycle: lookup SHALL return pre-update contents (no bypass); new contents visible next cycle.
REQ-019 mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
REQ-020 Update on hit: counter +1 if upd_taken, -1 otherwise, saturating at 0 and 2^CNT_BITS-1; target overwritten with upd_target when upd_taken.
REQ-021 Update on miss with upd_taken=1: entry replaced: valid=1, new tag, target=upd_target, counter=WT (2^(CNT_BITS-1)).
REQ-022 Update on miss with upd_taken=0: table unchanged (no allocation).
REQ-023 br_count +1 per upd_valid cycle; mispred_count +1 per mispredict cycle; both saturate at 32'hFFFFFFFF.
REQ-024 flush clears all valid bits next edge; counters/targets retained; flush has priority over a same-cycle update to the table, but statistics still count that update.
REQ-025 Latency: update to lookup-visible = 1 cycle; statistics visible 1 cycle after update.

Reset
REQ-026 rst low SHALL immediately clear all valid bits, set all counters to WNT (2^(CNT_BITS-1)-1), targets/tags to 0, br_count=mispred_count=0.
REQ-027 During reset outputs SHALL be pred_hit=0, pred_taken=0, pred_target=lookup_pc+4; mispredict follows REQ-019.
REQ-028 Reset asserted mid-update SHALL win; no partial entry written; normal operation from first rising edge after rst deasserts.

Verification
REQ-029 Cold lookup: after reset, lookup_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104.
REQ-030 Allocate: update pc=0x100, taken, target=0x80, pred_taken=0 -> mispredict=1; next cycle lookup 0x100 -> hit=1, taken=1, target=0x80; br_count=1, mispred_count=1.
REQ-031 Saturation (CNT_BITS=2): 4 taken updates then 1 not-taken on 0x100 -> still taken; 2 more not-taken -> pred_taken=0, pred_hit=1, target=0x104.
REQ-032 Aliasing (ENTRIES=16): allocate 0x100 then taken update at 0x140 (same index, different tag) -> lookup 0x100 misses, 0x140 hits.
REQ-033 Flush+update same cycle: flush=1 with taken update to 0x200 -> next cycle all lookups miss; br_count still increments.
REQ-034 Async reset mid-run: drop rst between edges with entries valid -> pred_hit=0 and counters 0 immediately, before next clk edge.
